// File: rtl/nonogram_pkg.sv
// Shared nonogram solver definitions: cell encoding and the line-conflict helper.
// Line vectors are handled at LINE_MAX width; narrower lines are zero-extended.
package nonogram_pkg;

    localparam logic CELL_FILLED = 1'b1;
    localparam logic CELL_EMPTY  = 1'b0;
    localparam int   LINE_MAX    = 64;

    // Known cells whose candidate value differs from the fixed value.
    // Zero-extended inputs leave the upper bits of the result at zero.
    function automatic logic [LINE_MAX-1:0] line_conflict(
        input logic [LINE_MAX-1:0] option,
        input logic [LINE_MAX-1:0] assigned,
        input logic [LINE_MAX-1:0] known
    );
        return (option ^ assigned) & known;
    endfunction

endpackage

// File: rtl/simplify.sv
// Purpose: flags a candidate line pattern that contradicts already-known cells (SIMPLIFY_MISMATCH_EN adds per-cell mismatch output).
// Latency: 1 cycle, registered valid/contradict; one check accepted per cycle.
// Backpressure: none; results stream out in issue order and cannot be stalled.
module simplify
    import nonogram_pkg::*;
#(
    parameter int size = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [size-1:0] assigned,
    input  logic [size-1:0] known,
    input  logic [size-1:0] option,
    output logic            valid,
    output logic            contradict
`ifdef SIMPLIFY_MISMATCH_EN
    ,
    output logic [size-1:0] mismatch_out
`endif
);

    logic [LINE_MAX-1:0] mismatch_full;
    logic                conflict;

    assign mismatch_full = line_conflict(LINE_MAX'(option), LINE_MAX'(assigned), LINE_MAX'(known));
    assign conflict      = |mismatch_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= 1'b0;
            contradict <= 1'b0;
        end else begin
            valid      <= valid_in;
            contradict <= valid_in ? conflict : 1'b0;
        end
    end

`ifdef SIMPLIFY_MISMATCH_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch_out <= '0;
        end else begin
            mismatch_out <= valid_in ? mismatch_full[size-1:0] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_simplify.sv
// Scoreboard bench for simplify: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_simplify;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic [2:0] assigned = '0;
    logic [2:0] known = '0;
    logic [2:0] option = '0;
    logic       valid;
    logic       contradict;
`ifdef SIMPLIFY_MISMATCH_EN
    logic [2:0] mismatch_out;
`endif

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [3:0] exp_q[$];   // {contradict, mismatch[2:0]}

    always #5 clk = ~clk;

    simplify #(.size(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .assigned   (assigned),
        .known      (known),
        .option     (option),
        .valid      (valid),
        .contradict (contradict)
`ifdef SIMPLIFY_MISMATCH_EN
        ,
        .mismatch_out (mismatch_out)
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one cycle of stimulus; a result is expected only for accepted requests.
    task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] k,
                         input logic [2:0] o, input logic exp_c, input logic [2:0] exp_m);
        valid_in = v;
        assigned = a;
        known    = k;
        option   = o;
        if (v && rst) exp_q.push_back({exp_c, exp_m});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1, expected no result at %0t", $time);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("contradict", 8'(contradict), 8'(e[3]));
`ifdef SIMPLIFY_MISMATCH_EN
                    check("mismatch_out", 8'(mismatch_out), 8'(e[2:0]));
                    check("contradict_or", 8'(contradict), 8'(|mismatch_out));
`endif
                end
            end else begin
                check("idle_valid", 8'(valid), 8'h0);
                check("idle_contradict", 8'(contradict), 8'h0);
`ifdef SIMPLIFY_MISMATCH_EN
                check("idle_mismatch", 8'(mismatch_out), 8'h0);
`endif
            end
        end
    end

    initial begin
        // Reset held for two edges with a request presented: it must be discarded.
        rst = 1'b0;
        valid_in = 1'b1; assigned = 3'b001; known = 3'b101; option = 3'b111;
        @(posedge clk); #1;
        mon_en = 1'b1;
        check("rst_valid_1", 8'(valid), 8'h0);
        check("rst_contradict_1", 8'(contradict), 8'h0);
        @(posedge clk); #1;
        check("rst_valid_2", 8'(valid), 8'h0);
        check("rst_contradict_2", 8'(contradict), 8'h0);
        rst = 1'b1;

        //    v     assigned known   option  c     mismatch
        drive(1'b1, 3'b001, 3'b101, 3'b111, 1'b1, 3'b100);  // cell 2 known empty
        drive(1'b1, 3'b001, 3'b101, 3'b011, 1'b0, 3'b000);  // cell 1 unknown
        drive(1'b1, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000);  // nothing known
        drive(1'b1, 3'b101, 3'b111, 3'b101, 1'b0, 3'b000);  // all known, equal
        drive(1'b1, 3'b101, 3'b111, 3'b100, 1'b1, 3'b001);  // all known, differs
        drive(1'b1, 3'b101, 3'b111, 3'b010, 1'b1, 3'b111);  // every cell wrong
        drive(1'b0, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000);  // idle with conflicting data

        // Back-to-back stream: contradict, ok, contradict, then idle.
        drive(1'b1, 3'b001, 3'b101, 3'b111, 1'b1, 3'b100);
        drive(1'b1, 3'b001, 3'b101, 3'b011, 1'b0, 3'b000);
        drive(1'b1, 3'b101, 3'b111, 3'b100, 1'b1, 3'b001);
        drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000);
        drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000);

        // Mid-stream reset: the first request completes, the one issued with reset is dropped.
        drive(1'b1, 3'b001, 3'b101, 3'b111, 1'b1, 3'b100);
        rst = 1'b0;
        drive(1'b1, 3'b001, 3'b101, 3'b111, 1'b1, 3'b100);
        check("midrst_valid", 8'(valid), 8'h0);
        check("midrst_contradict", 8'(contradict), 8'h0);
        rst = 1'b1;

        // First request after reset is accepted on the first edge with rst high.
        drive(1'b1, 3'b110, 3'b011, 3'b100, 1'b1, 3'b010);
        drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000);
        drive(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000);

        check("queue_drained", 8'(exp_q.size()), 8'h0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
